counter_preset_sequencer: RTL and testbench
===========================================

Name: counter_preset_sequencer

Overview:
- Upstream feeder for synchronous_counter: drives its load/data pins.
- Accepts preset values over a valid/ready handshake and buffers them in a small FIFO.
- Issues each preset as a one-cycle load when the counter reaches terminal count, or on a force request.
- Watches the counter's count output to time each load.

Parameters:
WIDTH, 4, width of preset data and count
DEPTH, 4, FIFO entries; power of two, at least 2
TERM, 4'hF, count value that triggers a scheduled load

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  preset request valid
req_data  input  WIDTH  preset value
req_ready  output  1  FIFO can accept; equals !full
force  input  1  load head entry now, ignoring count
count  input  WIDTH  counter's current value (feedback)
load  output  1  to counter load pin
data  output  WIDTH  to counter data pin
pending  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  high when state != IDLE

Behaviour:
- Reset (async, rst=1):
  - FIFO flushed, pending=0, state=IDLE.
  - load=0, data=0, req_ready=1, busy=0.
  - Outputs change immediately, with no clock edge needed.
- Push: at an edge with req_valid && req_ready, req_data is written at the tail and pending increments.
- Push when full: req_ready=0, so the request is not taken. The source holds req_valid and req_data stable until accepted.
- data = FIFO head when pending>0, else 0. Data is driven from registered storage.
- load is combinational from registered state and inputs: load = (state==ARMED) && ((count==TERM) || force).
  - The counter samples load/data at the same edge.
  - Resulting counter sequence: ...TERM-1, TERM, data, data+1...
  - The wrap to 0 is replaced by the preset.
- Pop: at any edge where load=1, the head is removed and pending decrements.
- Simultaneous push and pop: both take effect and pending is unchanged. Push at full is never accepted, even during a pop, because req_ready is registered-state based.
- State machine:
  - IDLE: pending==0; load suppressed. Next state is ARMED when pending becomes nonzero. One-cycle latency: the entry pushed at edge k is loadable from cycle k+1.
  - ARMED: waits for count==TERM or force. On load, next state is GUARD.
  - GUARD: exactly one cycle; load suppressed and force ignored. Prevents re-trigger when data==TERM. Next state is ARMED if pending>0 after the pop, else IDLE.
- force in IDLE or GUARD is ignored and not remembered.
- Entries load strictly in FIFO order. Pointers wrap modulo DEPTH; pending saturates by construction at 0..DEPTH.
- busy=1 in ARMED and GUARD.
- Reset mid-operation clears everything, including an in-flight load; no stale entry is issued after release.

Test Plan:
- Reset: rst=1 for 2 cycles -> load=0, data=0, req_ready=1, pending=0, busy=0. Also assert rst between edges while pending=3 -> load drops at once, pending=0, and no load at the next count=15.
- Scheduled load (sequencer wired to synchronous_counter, counter free-running from 0): push 4'hA at count=2 -> pending=1, busy=1; load=1 and data=A only in the count=15 cycle; counter then shows 10, 11, 12; pending=0, state returns to IDLE.
- Fill/order: push 1,2,3,4 back-to-back -> pending=4, req_ready=0; hold req_valid with 5 -> not accepted. Loads occur at successive count=15 cycles with data 1, 2, 3, 4 in order. After the first pop, req_ready=1 and 5 is accepted.
- Force: push 7, wait for ARMED, count=3, force=1 -> load=1 that cycle, counter next 7. force held high into the GUARD cycle with 9 queued -> no load; the next force in ARMED loads 9.
- Simultaneous push/pop: pending=2, push 6 in the count=15 cycle -> load=1 and push accepted, pending stays 2, 6 is at the tail.
- data==TERM: queue F then 2 -> load F at count=15; counter shows 15 during GUARD with no reload; counter wraps to 0; 2 loads at the following count=15, 16 cycles later.

Source files
------------

// File: rtl/counter_preset_sequencer_if.sv
// Preset request handshake plus counter load/feedback bus for counter_preset_sequencer.
// The force input is named force_req because force is a reserved word in SystemVerilog.
interface counter_preset_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    logic             force_req;
    logic [WIDTH-1:0] count;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [PW-1:0]    pending;
    logic             busy;

    // Source / counter side: drives requests and count feedback.
    modport master (
        output req_valid,
        output req_data,
        output force_req,
        output count,
        input  req_ready,
        input  load,
        input  data,
        input  pending,
        input  busy
    );

    // Sequencer side.
    modport slave (
        input  req_valid,
        input  req_data,
        input  force_req,
        input  count,
        output req_ready,
        output load,
        output data,
        output pending,
        output busy
    );
endinterface

// File: rtl/counter_preset_sequencer.sv
// Buffers preset values in a FIFO and issues each one as a single-cycle load to a
// synchronous counter, either at terminal count or on a force request.
module counter_preset_sequencer #(
    parameter int unsigned      WIDTH = 4,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] TERM  = WIDTH'(4'hF)
) (
    input logic                         clk,
    input logic                         rst,
    counter_preset_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [PW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             load;

    assign full  = (cnt == PW'(DEPTH));
    assign empty = (cnt == '0);
    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign push  = bus.req_valid && !full;
    assign load  = (state == ARMED) && ((bus.count == TERM) || bus.force_req);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, load})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // GUARD sees the post-pop occupancy, so it can re-arm straight onto the next entry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : ARMED;
            ARMED:   state_nxt = load ? GUARD : ARMED;
            GUARD:   state_nxt = empty ? IDLE : ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = !full;
    assign bus.load      = load;
    assign bus.data      = empty ? '0 : mem[rptr];
    assign bus.pending   = cnt;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_counter_preset_sequencer.sv
// Directed bench: sequencer drives a behavioural synchronous counter; loads are scored against a FIFO queue.
module tb_counter_preset_sequencer;
    logic       clk;
    logic       rst;
    logic [3:0] ctr;
    int         errors;
    int         checks;
    int         n_loads;
    int         loads_before;
    int         gap;
    logic [3:0] sb[$];

    counter_preset_sequencer_if #(.WIDTH(4), .DEPTH(4)) bus ();

    counter_preset_sequencer #(
        .WIDTH (4),
        .DEPTH (4),
        .TERM  (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous_counter: load has priority over increment.
    always @(posedge clk or posedge rst) begin
        if (rst)           ctr <= 4'h0;
        else if (bus.load) ctr <= bus.data;
        else               ctr <= ctr + 4'h1;
    end
    assign bus.count = ctr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input logic [3:0] v);
        for (int i = 0; i < 40; i++) begin
            if (ctr == v) break;
            step();
        end
        check("wait_count", ctr, v);
    endtask

    task automatic push(input logic [3:0] v);
        bus.req_valid = 1'b1;
        bus.req_data  = v;
        for (int i = 0; i < 40; i++) begin
            if (bus.req_ready) break;
            step();
        end
        check("push_ready", bus.req_ready, 1);
        sb.push_back(v);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        check("drain", sb.size(), 0);
        step();
        check("drain_busy", bus.busy, 0);
        check("drain_pending", bus.pending, 0);
    endtask

    // Every load must carry the oldest queued preset and be triggered by TERM or force.
    always @(negedge clk) begin
        if (!rst && bus.load) begin
            n_loads++;
            check("load_trigger", (bus.count == 4'hF) || bus.force_req, 1);
            if (sb.size() == 0) begin
                check("load_unexpected", 1, 0);
            end else begin
                check("load_data", bus.data, sb[0]);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        errors        = 0;
        checks        = 0;
        n_loads       = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 4'h0;
        bus.force_req = 1'b0;

        // Reset state
        step();
        step();
        check("rst_load", bus.load, 0);
        check("rst_data", bus.data, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_pending", bus.pending, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;

        // Scheduled load of A at terminal count
        wait_count(4'h2);
        push(4'hA);
        check("sched_pending", bus.pending, 1);
        step();
        check("sched_busy", bus.busy, 1);
        wait_count(4'hE);
        check("sched_noload14", bus.load, 0);
        step();
        check("sched_load", bus.load, 1);
        check("sched_data", bus.data, 4'hA);
        step();
        check("sched_ctr10", ctr, 4'hA);
        check("sched_guard_load", bus.load, 0);
        check("sched_guard_busy", bus.busy, 1);
        check("sched_pending0", bus.pending, 0);
        step();
        check("sched_ctr11", ctr, 4'hB);
        check("sched_idle", bus.busy, 0);
        step();
        check("sched_ctr12", ctr, 4'hC);

        // Fill to full, hold a fifth request, then drain in order
        wait_count(4'h0);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        push(4'h4);
        check("fill_pending", bus.pending, 4);
        check("fill_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_data  = 4'h5;
        step();
        step();
        step();
        check("full_hold_pending", bus.pending, 4);
        check("full_hold_ready", bus.req_ready, 0);
        loads_before = n_loads;
        push(4'h5);
        check("full_one_pop", n_loads - loads_before, 1);
        check("full_accept_pending", bus.pending, 4);
        wait_empty();

        // Force load, then force held through GUARD
        wait_count(4'h0);
        push(4'h7);
        push(4'h9);
        wait_count(4'h3);
        bus.force_req = 1'b1;
        #0;
        check("force_load", bus.load, 1);
        check("force_data", bus.data, 4'h7);
        step();
        check("force_ctr7", ctr, 4'h7);
        check("force_guard_noload", bus.load, 0);
        check("force_guard_pending", bus.pending, 1);
        step();
        check("force_load9", bus.load, 1);
        check("force_data9", bus.data, 4'h9);
        step();
        bus.force_req = 1'b0;
        check("force_ctr9", ctr, 4'h9);

        // Simultaneous push and pop at terminal count
        push(4'h3);
        push(4'h8);
        wait_count(4'hF);
        check("simul_pending_before", bus.pending, 2);
        check("simul_load", bus.load, 1);
        push(4'h6);
        check("simul_pending_after", bus.pending, 2);
        check("simul_ctr", ctr, 4'h3);
        wait_empty();

        // Preset equal to TERM must not retrigger during GUARD
        wait_count(4'h1);
        push(4'hF);
        push(4'h2);
        wait_count(4'hF);
        check("term_load", bus.load, 1);
        check("term_data", bus.data, 4'hF);
        step();
        check("term_guard_ctr", ctr, 4'hF);
        check("term_guard_noload", bus.load, 0);
        check("term_guard_busy", bus.busy, 1);
        step();
        check("term_wrap", ctr, 4'h0);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.load) break;
            step();
            gap++;
        end
        check("term_gap", gap, 15);
        check("term_data2", bus.data, 4'h2);
        step();
        check("term_ctr2", ctr, 4'h2);
        step();

        // Asynchronous reset while three entries are pending and a load is in flight
        wait_count(4'h2);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        check("mid_pending3", bus.pending, 3);
        wait_count(4'hF);
        check("mid_load_before", bus.load, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_load", bus.load, 0);
        check("mid_rst_pending", bus.pending, 0);
        check("mid_rst_data", bus.data, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        step();
        rst = 1'b0;
        loads_before = n_loads;
        wait_count(4'hF);
        check("mid_no_stale_load", bus.load, 0);
        step();
        check("mid_wrap", ctr, 4'h0);
        check("mid_no_loads", n_loads - loads_before, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
